// File: rtl/timer_pkg.sv
// Shared types and helpers for the level countdown timer.
// Two-digit BCD time values, state encoding and binary->BCD conversion.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    EXPIRED
  } timer_state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam int MAX_SECONDS = 99;

  // Clamp to 99, then split into {tens, ones}
  function automatic logic [7:0] bin_to_bcd2(input logic [6:0] b);
    logic [6:0] v;
    logic [3:0] t;
    logic [3:0] o;
    v = (b > 7'(MAX_SECONDS)) ? 7'(MAX_SECONDS) : b;
    t = 4'(v / 7'd10);
    o = 4'(v % 7'd10);
    return {t, o};
  endfunction

endpackage

// File: rtl/level_timer_bcd2_add_dec.sv
// Two-digit BCD add with optional decrement.
// Sum saturates at 99; the decrement never goes below 00.
module bcd2_add_dec
  import timer_pkg::*;
(
  input  bcd_digit_t a_tens,
  input  bcd_digit_t a_ones,
  input  bcd_digit_t b_tens,
  input  bcd_digit_t b_ones,
  input  logic       dec,
  output bcd_digit_t r_tens,
  output bcd_digit_t r_ones,
  output logic       zero
);

  logic [4:0] os;
  logic [4:0] ts;
  logic       oc;
  logic       sat;
  bcd_digit_t st;
  bcd_digit_t so;

  // Add with decimal carry, saturate on tens carry-out, then decrement
  always_comb begin
    os  = {1'b0, a_ones} + {1'b0, b_ones};
    oc  = (os > 5'd9);
    if (oc) os = os - 5'd10;
    ts  = {1'b0, a_tens} + {1'b0, b_tens} + {4'd0, oc};
    sat = (ts > 5'd9);
    st  = sat ? 4'd9 : ts[3:0];
    so  = sat ? 4'd9 : os[3:0];
    r_tens = st;
    r_ones = so;
    if (dec && !(st == 4'd0 && so == 4'd0)) begin
      if (so == 4'd0) begin
        r_tens = st - 4'd1;
        r_ones = 4'd9;
      end else begin
        r_ones = so - 4'd1;
      end
    end
    zero = (r_tens == 4'd0) && (r_ones == 4'd0);
  end

endmodule

// File: rtl/level_timer.sv
// Level countdown timer: BCD seconds, bonus time, pause, expiry pulse.
// All outputs come straight from registers.
module level_timer
  import timer_pkg::*;
#(
  parameter int START_SECONDS = 60,
  parameter int LOW_THRESHOLD = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic       pause,
  input  logic       bonus,
  input  logic [6:0] bonus_secs,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       running,
  output logic       time_up,
  output logic       low_time
);

  localparam bcd_digit_t START_T = bcd_digit_t'(START_SECONDS / 10);
  localparam bcd_digit_t START_O = bcd_digit_t'(START_SECONDS % 10);
  localparam logic [7:0] LOW_BCD = {4'(LOW_THRESHOLD / 10),
                                    4'(LOW_THRESHOLD % 10)};

  timer_state_t state_q, state_n;
  bcd_digit_t   tens_q, ones_q;
  bcd_digit_t   tens_n, ones_n;
  logic         tu_n, low_n;
  logic         bonus_ok, dec;
  logic [7:0]   bonus_bcd;
  bcd_digit_t   r_tens, r_ones;
  logic         r_zero;

  assign bonus_ok  = bonus && (state_q == RUN || state_q == PAUSED);
  assign dec       = tick && (state_q == RUN) && !pause;
  assign bonus_bcd = bonus_ok ? bin_to_bcd2(bonus_secs) : 8'h00;

  bcd2_add_dec u_arith (
    .a_tens (tens_q),
    .a_ones (ones_q),
    .b_tens (bonus_bcd[7:4]),
    .b_ones (bonus_bcd[3:0]),
    .dec    (dec),
    .r_tens (r_tens),
    .r_ones (r_ones),
    .zero   (r_zero)
  );

  // Next state, next digits and next flag values
  always_comb begin
    state_n = state_q;
    tens_n  = tens_q;
    ones_n  = ones_q;
    tu_n    = 1'b0;
    if (start) begin
      state_n = RUN;
      tens_n  = START_T;
      ones_n  = START_O;
    end else begin
      unique case (state_q)
        RUN: begin
          tens_n = r_tens;
          ones_n = r_ones;
          if (dec && r_zero) begin
            state_n = EXPIRED;
            tu_n    = 1'b1;
          end else if (pause) begin
            state_n = PAUSED;
          end
        end
        PAUSED: begin
          tens_n = r_tens;
          ones_n = r_ones;
          if (!pause) state_n = RUN;
        end
        default: ;
      endcase
    end
    low_n = (state_n == RUN || state_n == PAUSED) &&
            ({tens_n, ones_n} != 8'h00) &&
            ({tens_n, ones_n} <= LOW_BCD);
  end

  // State, digit and output flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      tens_q   <= START_T;
      ones_q   <= START_O;
      time_up  <= 1'b0;
      low_time <= 1'b0;
    end else begin
      state_q  <= state_n;
      tens_q   <= tens_n;
      ones_q   <= ones_n;
      time_up  <= tu_n;
      low_time <= low_n;
    end
  end

  assign tens    = tens_q;
  assign ones    = ones_q;
  assign running = (state_q == RUN);

endmodule

// File: doc/level_timer.md
# level_timer

Two-digit BCD countdown of the remaining level time. It sits directly downstream of the one-second divider and consumes its one-cycle `slowClk` pulse as `tick`. It drives the on-screen time digits and the low-time warning, and it tells the game controller when time has run out. Only the `tick` pulse from the divider is used; that divider's `duty50` output is not consumed here.

## Interface
- `START_SECONDS`, 60: value loaded on `start`; legal range 1..99.
- `LOW_THRESHOLD`, 10: `low_time` asserts while remaining time is at or below this value and above 0.
- `clk` input 1: system clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `tick` input 1: one-cycle pulse per second from the divider's `slowClk` output.
- `start` input 1: pulse; load `START_SECONDS` and begin running.
- `pause` input 1: level; while high, ticks are ignored.
- `bonus` input 1: pulse; add `bonus_secs` to remaining time.
- `bonus_secs` input 7: binary bonus amount, 0..99; values above 99 are treated as 99.
- `tens` output 4: BCD tens digit.
- `ones` output 4: BCD ones digit.
- `running` output 1: high in RUN.
- `time_up` output 1: one-cycle pulse on expiry.
- `low_time` output 1: warning flag.

## Operation
- States:
  - IDLE: after reset; digits hold.
  - RUN: counting down.
  - PAUSED: RUN with `pause` high.
  - EXPIRED: time reached 00; waits for `start`.
- Transitions:
  - Any state + `start` → RUN with `START_SECONDS` loaded. `start` has highest priority; a `tick` or `bonus` in the same cycle is ignored.
  - RUN + `pause` → PAUSED.
  - PAUSED + !`pause` → RUN.
  - RUN + `tick` with value 01 (net of any same-cycle bonus) → EXPIRED.
- Decrement: in RUN, each `tick` subtracts 1 with BCD borrow. Example: 10 → 09.
- Bonus:
  - Accepted in RUN and PAUSED; ignored in IDLE and EXPIRED.
  - Result saturates at 99.
  - `bonus` and `tick` in the same RUN cycle: result = min(value + bonus_secs, 99) − 1, applied atomically.
  - If the value is 01 and a same-cycle bonus is ≥ 1, the timer does not expire.
- Ticks in IDLE, PAUSED and EXPIRED have no effect.
- `time_up` is high for exactly one cycle, the same cycle in which the digits first read 00 and the state first reads EXPIRED. The counter never wraps below 00.
- `low_time` = (1 ≤ value ≤ `LOW_THRESHOLD`) in RUN or PAUSED; it is low in IDLE and EXPIRED.
- Arithmetic:
  - Internal value is held as two BCD digits.
  - `bonus_secs` is converted binary → BCD (0..99) combinationally.
  - The add-then-subtract path is a two-digit BCD adder followed by a decrement, with a saturation check on the adder carry-out from the tens digit.

## Timing
- Reset values:
  - State IDLE.
  - `tens` = `START_SECONDS`/10 and `ones` = `START_SECONDS`%10 (the display shows the full time before start).
  - `running` = 0, `time_up` = 0, `low_time` = 0.
- Latency: every input sampled at edge N is visible on the outputs after edge N (one register stage). No combinational input→output path exists.
- `reset` asserted mid-run aborts immediately, asynchronously, to the reset values. No `time_up` is generated by reset.
- `pause` is level-sensitive and sampled each cycle. A `tick` in the same cycle that `pause` rises is ignored.
- `tick` has no minimum spacing; back-to-back ticks decrement on consecutive cycles. The bench relies on this.

## Structure
- Package `timer_pkg` holds:
  - `timer_state_t` enum: IDLE, RUN, PAUSED, EXPIRED.
  - `bcd_digit_t` (logic [3:0]).
  - `MAX_SECONDS` = 99.
  - Function `bin_to_bcd2` (7-bit → two digits, clamped at 99).
- One sub-module, `bcd2_add_dec`: combinational two-digit BCD add with optional decrement and saturation at 99 and floor at 00. Outputs the result digits and a `zero` flag.
- Top level: state register, digit registers, and `time_up`/`low_time` output registers.

## Test plan
- Reset release, then `start`, then 3 ticks → digits 60, 59, 58, 57; `running` = 1; `low_time` = 0.
- Load 60, 50 ticks → value 10, `low_time` = 1. Then 9 ticks → 01. Then 1 tick → 00 with `time_up` high for exactly 1 cycle and state EXPIRED. Further ticks → 00 held, no second `time_up`.
- At 05 in RUN, `bonus` with `bonus_secs` = 97 → 99 (saturated). At 01, `bonus` with `bonus_secs` = 3 together with `tick` → 03, no `time_up`.
- At 30, `pause` high, 5 ticks → 30 held, `running` = 0. Then `pause` low, 1 tick → 29. Also: `bonus` with `bonus_secs` = 4 while paused → 34.
- At 20, `start` and `tick` in the same cycle → 60. In EXPIRED, `start` → 60 and RUN.
- At 15 in RUN, assert `reset` asynchronously between edges → outputs return to reset values before the next edge; `time_up` never pulses.
